// File: rtl/det_pkg.sv
// Shared types and constants for the determinant-engine arbiter.
package det_pkg;

  localparam int DET_W_DEF = 32;
  localparam int NREQ      = 2;
  localparam int JOBS_W    = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_REL   = 3'd4
  } state_t;

  // One-hot flag vector {rel, resp, wait, start, idle}, indexed by state encoding.
  function automatic logic [4:0] state_flags(state_t s);
    state_flags = 5'd1 << s;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: ptr names the requester that wins a tie.
module rr_arb2
  import det_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            ptr,
  output logic [NREQ-1:0] gnt
);

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/det_engine_arbiter.sv
// Arbitrates two requesters onto one determinant engine and returns its result.
// Optional WAIT-state timeout enabled by defining DET_TIMEOUT_EN.
module det_engine_arbiter
  import det_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int          DET_W          = DET_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   rsp_ack,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DET_W-1:0]  rsp_det,
  output logic              rsp_err,
  output logic              eng_start,
  output logic              eng_ack,
  input  logic              eng_done,
  input  logic [DET_W-1:0]  eng_det,
  output logic [JOBS_W-1:0] jobs_done,
  output logic              q_Idle,
  output logic              q_Start,
  output logic              q_Wait,
  output logic              q_Resp,
  output logic              q_Rel
);

  state_t          state, state_n;
  logic [NREQ-1:0] pick;
  logic            ptr;
  logic            ack_hit;
  logic            timed_out;
  logic [4:0]      flags;

  rr_arb2 u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (pick)
  );

  assign ack_hit = |(rsp_ack & gnt);
  assign {q_Rel, q_Resp, q_Wait, q_Start, q_Idle} = flags;

`ifdef DET_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        err_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      tmo_cnt <= (state == S_WAIT) ? tmo_cnt + 32'd1 : '0;
      if (state == S_WAIT && (eng_done || timed_out))
        err_q <= !eng_done;
    end
  end

  // A late eng_done on the final WAIT cycle still wins over the timeout.
  assign timed_out = (state == S_WAIT) && !eng_done && (tmo_cnt == TIMEOUT_CYCLES - 32'd1);
  assign rsp_err   = err_q;
`else
  assign timed_out = 1'b0;
  assign rsp_err   = 1'b0;
  // TIMEOUT_CYCLES has no effect in this build; kept so instantiations stay uniform.
  if (TIMEOUT_CYCLES == 0) begin : g_tmo_cfg
  end
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (|req) state_n = S_START;
      S_START: state_n = S_WAIT;
      S_WAIT:  if (eng_done || timed_out) state_n = S_RESP;
      S_RESP:  if (ack_hit) state_n = S_REL;
      S_REL:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state change.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_det   <= '0;
      eng_start <= 1'b0;
      eng_ack   <= 1'b0;
      jobs_done <= '0;
      ptr       <= 1'b0;
      flags     <= state_flags(S_IDLE);
    end else begin
      eng_start <= (state_n == S_START);
      eng_ack   <= (state_n == S_REL);
      rsp_valid <= (state_n == S_RESP) ? gnt : '0;
      flags     <= state_flags(state_n);
      if (state == S_IDLE && |req) begin
        gnt <= pick;
        ptr <= pick[0];
      end
      if (state == S_REL)
        gnt <= '0;
      if (state == S_WAIT) begin
        if (eng_done)       rsp_det <= eng_det;
        else if (timed_out) rsp_det <= '0;
      end
      if (state == S_RESP && ack_hit && !rsp_err)
        jobs_done <= jobs_done + 1'b1;
    end
  end

endmodule
